// File: rtl/mem_access_unit_if.sv
// Bundle of CPU-side request/response and word-memory signals for mem_access_unit.
// The unit itself takes the slave view; the environment (CPU + memory) takes the master view.
interface mem_access_unit_if;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        sign_ext;
    logic [17:0] addr;
    logic [31:0] wdata;
    logic        ready;
    logic        done;
    logic        err;
    logic [31:0] rdata;
    logic [17:0] mem_address;
    logic [31:0] mem_write_data;
    logic        memRead;
    logic        memWrite;
    logic [31:0] mem_read_data;

    modport slave (
        input  req, we, size, sign_ext, addr, wdata, mem_read_data,
        output ready, done, err, rdata, mem_address, mem_write_data, memRead, memWrite
    );

    modport master (
        output req, we, size, sign_ext, addr, wdata, mem_read_data,
        input  ready, done, err, rdata, mem_address, mem_write_data, memRead, memWrite
    );
endinterface

// File: rtl/mem_access_unit.sv
// Byte/halfword/word load-store initiator on a word-addressed, big-endian memory.
// Sub-word stores are read-modify-write; all outputs are registered Moore outputs.
module mem_access_unit #(
    parameter int MEM_LATENCY = 1
) (
    input  logic             clk,
    input  logic             reset,
    mem_access_unit_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_DONE
    } state_t;

    localparam logic [3:0] LAST_CNT = 4'(MEM_LATENCY - 1);

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic        we_q;
    logic [1:0]  size_q;
    logic        sign_ext_q;
    logic [17:0] addr_q;
    logic [31:0] wdata_q;
    logic        ready_q;
    logic        done_q;
    logic        err_q;
    logic [31:0] rdata_q;
    logic [17:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic        mem_read_q;
    logic        mem_write_q;

    logic        misaligned_d;
    logic        needs_read_d;
    logic [7:0]  lane_byte_d;
    logic [15:0] lane_half_d;
    logic [31:0] load_word_d;
    logic [31:0] merge_word_d;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        misaligned_d = 1'b0;
        if (bus.size == 2'b01)
            misaligned_d = bus.addr[0];
        else if (bus.size[1])
            misaligned_d = |bus.addr[1:0];
        // Loads and sub-word stores both need the current word first.
        needs_read_d = ~bus.we | ~bus.size[1];
    end

    always_comb begin
        lane_byte_d = 8'h00;
        case (addr_q[1:0])
            2'd0:    lane_byte_d = bus.mem_read_data[31:24];
            2'd1:    lane_byte_d = bus.mem_read_data[23:16];
            2'd2:    lane_byte_d = bus.mem_read_data[15:8];
            default: lane_byte_d = bus.mem_read_data[7:0];
        endcase
        lane_half_d = addr_q[1] ? bus.mem_read_data[15:0] : bus.mem_read_data[31:16];

        case (size_q)
            2'b00:   load_word_d = {{24{sign_ext_q & lane_byte_d[7]}}, lane_byte_d};
            2'b01:   load_word_d = {{16{sign_ext_q & lane_half_d[15]}}, lane_half_d};
            default: load_word_d = bus.mem_read_data;
        endcase

        merge_word_d = bus.mem_read_data;
        case (size_q)
            2'b00: begin
                case (addr_q[1:0])
                    2'd0:    merge_word_d[31:24] = wdata_q[7:0];
                    2'd1:    merge_word_d[23:16] = wdata_q[7:0];
                    2'd2:    merge_word_d[15:8]  = wdata_q[7:0];
                    default: merge_word_d[7:0]   = wdata_q[7:0];
                endcase
            end
            2'b01: begin
                if (addr_q[1])
                    merge_word_d[15:0] = wdata_q[15:0];
                else
                    merge_word_d[31:16] = wdata_q[15:0];
            end
            default: merge_word_d = wdata_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            we_q        <= 1'b0;
            size_q      <= 2'b00;
            sign_ext_q  <= 1'b0;
            addr_q      <= 18'd0;
            wdata_q     <= 32'd0;
            ready_q     <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= 32'd0;
            mem_addr_q  <= 18'd0;
            mem_wdata_q <= 32'd0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.req) begin
                        we_q       <= bus.we;
                        size_q     <= bus.size;
                        sign_ext_q <= bus.sign_ext;
                        addr_q     <= bus.addr;
                        wdata_q    <= bus.wdata;
                        ready_q    <= 1'b0;
                        cnt_q      <= 4'd0;
                        if (misaligned_d) begin
                            err_q   <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            mem_addr_q <= {bus.addr[17:2], 2'b00};
                            if (needs_read_d) begin
                                mem_read_q <= 1'b1;
                                state_q    <= S_RD;
                            end else begin
                                mem_write_q <= 1'b1;
                                mem_wdata_q <= bus.wdata;
                                state_q     <= S_WR;
                            end
                        end
                    end
                end
                S_RD: begin
                    if (cnt_q == LAST_CNT) begin
                        cnt_q      <= 4'd0;
                        mem_read_q <= 1'b0;
                        if (we_q) begin
                            mem_write_q <= 1'b1;
                            mem_wdata_q <= merge_word_d;
                            state_q     <= S_WR;
                        end else begin
                            rdata_q <= load_word_d;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                S_WR: begin
                    if (cnt_q == LAST_CNT) begin
                        cnt_q       <= 4'd0;
                        mem_write_q <= 1'b0;
                        mem_wdata_q <= 32'd0;
                        done_q      <= 1'b1;
                        state_q     <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    err_q   <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.ready          = ready_q;
    assign bus.done           = done_q;
    assign bus.err            = err_q;
    assign bus.rdata          = rdata_q;
    assign bus.mem_address    = mem_addr_q;
    assign bus.mem_write_data = mem_wdata_q;
    assign bus.memRead        = mem_read_q;
    assign bus.memWrite       = mem_write_q;
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store initiator that sits between the CPU datapath and the word-addressed `memory_block`. It turns byte, halfword and word load/store requests into `memRead`/`memWrite` transactions on the 32-bit word memory interface. Sub-word stores are done as read-modify-write, and sub-word loads are extracted with sign or zero extension. Misaligned accesses are reported as errors and never reach memory.

## Interface
- `MEM_LATENCY`, default 1: cycles `memRead`/`memWrite` are held per memory access; legal range 1..15.
- `clk` in, 1: rising-edge clock.
- `reset` in, 1: asynchronous, active-high reset.
- `req` in, 1: request strobe; sampled only when `ready`=1.
- `we` in, 1: 1 = store, 0 = load.
- `size` in, 2: 00 = byte, 01 = halfword, 10 = word; 11 is treated as word.
- `sign_ext` in, 1: for loads, 1 = sign-extend and 0 = zero-extend the sub-word.
- `addr` in, 18: byte address.
- `wdata` in, 32: store data; the sub-word is taken from the LSBs.
- `ready` out, 1: high only in IDLE.
- `done` out, 1: one-cycle completion pulse.
- `err` out, 1: misalignment flag; valid only with `done`.
- `rdata` out, 32: load result; holds until the next load completes.
- `mem_address` out, 18: word-aligned address, with [1:0] always 00.
- `mem_write_data` out, 32: merged write word.
- `memRead` out, 1: memory read enable.
- `memWrite` out, 1: memory write enable.
- `mem_read_data` in, 32: memory read data. It is combinational from `mem_address`/`memRead` and is sampled at the clock edge ending the last read cycle.

## Operation
- Moore FSM with states IDLE, RD, WR, DONE. All memory-side outputs decode from state and latched request registers, so they are glitch-free.
- **Accept (IDLE):** `req`=1 with `ready`=1 latches `we`, `size`, `sign_ext`, `addr`, `wdata`.
  - `req` while not ready is ignored; there is no queueing.
- **Alignment check:**
  - A halfword is misaligned when `addr[0]`=1.
  - A word is misaligned when `addr[1:0]`≠00.
  - Misaligned: IDLE→DONE with `err`=1. No `memRead`/`memWrite` is asserted and `rdata` is unchanged.
- **Next state after accept (aligned):**
  - Loads and sub-word stores go IDLE→RD.
  - Word stores go IDLE→WR.
- **RD:**
  - `memRead`=1 and `mem_address`={addr[17:2],2'b00} for `MEM_LATENCY` cycles, counted by a 4-bit counter.
  - At the edge ending the last RD cycle, `mem_read_data` is captured.
  - Load: `rdata` is updated and the FSM goes to DONE.
  - Sub-word store: the merge word is built and the FSM goes to WR.
- **Byte order is big-endian.**
  - Byte lane k = addr[1:0] occupies bits [31-8k -: 8].
  - Halfword at addr[1]=0 is bits [31:16]; at addr[1]=1 it is bits [15:0].
- **Load extension:**
  - Byte: bit 7 of the lane is replicated into [31:8] when `sign_ext`=1, otherwise [31:8]=0.
  - Halfword: the same rule applies using bit 15 of the lane.
- **Store merge:** only the addressed lane is replaced with `wdata[7:0]` or `wdata[15:0]`; the other lanes keep the captured read word. A word store uses `wdata` unmodified.
- **WR:**
  - `memWrite`=1 and `mem_write_data`=merged word for `MEM_LATENCY` cycles, then the FSM goes to DONE.
  - `mem_write_data`=0 outside WR.
- **DONE:** `done`=1 for exactly one cycle (with `err` if the access was misaligned), then the FSM returns to IDLE.
- `memRead` and `memWrite` are never high in the same cycle. `mem_address` holds its value from RD through WR.

## Timing
- **Reset values:** state IDLE, `ready`=1, `done`=0, `err`=0, `rdata`=0, `mem_address`=0, `mem_write_data`=0, `memRead`=0, `memWrite`=0, counter=0.
- With L=`MEM_LATENCY` and the request accepted at edge 0:
  - Load: `memRead` high in cycles 1..L; `done` in cycle L+1; `rdata` valid from cycle L+1.
  - Sub-word store: `memRead` in cycles 1..L; `memWrite` in cycles L+1..2L; `done` in cycle 2L+1.
  - Word store: `memWrite` in cycles 1..L; `done` in cycle L+1.
  - Misaligned: `done`+`err` in cycle 1.
- Throughput: `ready` returns in the cycle after DONE, so back-to-back requests have a one-cycle IDLE gap.
- **Reset mid-operation:**
  - All outputs go to their reset values immediately and asynchronously.
  - No `done` is produced.
  - A store reset during RD performs no write.
  - Reset during WR leaves the memory word content undefined.

## Test plan
- **Word store then load, L=1:** store `wdata`=0xDEADBEEF at `addr`=0x00010, then load word at 0x00010. Required:
  - Store: `memWrite` for 1 cycle with `mem_address`=0x00010; `done` in cycle 2.
  - Load: `rdata`=0xDEADBEEF in cycle 2.
- **Byte store read-modify-write:** memory word at 0x00020 = 0x11223344; store byte 0xAB to 0x00022. Required: memory becomes 0x1122AB44; `memRead` in cycle 1, `memWrite` in cycle 2, `done` in cycle 3.
- **Byte load extension:** word at 0x00020 = 0x11228044. Required:
  - Load byte at 0x00022 with `sign_ext`=1 → `rdata`=0xFFFFFF80.
  - Same load with `sign_ext`=0 → `rdata`=0x00000080.
  - Halfword load at 0x00020 with sign → `rdata`=0x00001122.
- **Misalignment:** word load at 0x00021 and halfword store at 0x00023. Required: `done`=`err`=1 in cycle 1; `memRead`/`memWrite` stay 0; `rdata` unchanged.
- **Latency and request handling, `MEM_LATENCY`=3:** halfword store 0xCAFE to 0x00042 over word 0x12345678. Required:
  - `memRead` in cycles 1-3, `memWrite` in cycles 4-6, result 0x1234CAFE, `done` in cycle 7.
  - `req` pulsed during cycle 2 is ignored.
- **Reset mid-RD:** assert `reset` in cycle 1 of a byte store. Required: all outputs reset immediately; memory word unchanged; `ready`=1 after release.
